// File: rtl/serial_borrow_subtractor.sv
// ---------------------------------------------------------------------------
// serial_borrow_subtractor
//
// Digit-serial subtractor computing c = a - b - borrow_in (mod 2^N).
// It processes W bits per clock and chains a registered borrow between
// digits. A valid/ready handshake is used on both the operand and result
// sides. Only one operation is in flight at a time.
//
// Parameters:
//   N : operand/result width, must be a multiple of W (default 32)
//   W : digit width per clock, 1 <= W <= N            (default 8)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands present on a, b, borrow_in
//   in_ready   out  block is idle and can accept operands
//   a          in   minuend (N bits)
//   b          in   subtrahend (N bits)
//   borrow_in  in   borrow subtracted at the LSB
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer accepts the result
//   c          out  difference modulo 2^N
//   borrow_out out  1 when a < b + borrow_in (unsigned)
//   overflow   out  signed overflow flag
//
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN
//   Defined   : sign bits are captured at acceptance and overflow is
//               computed when the last digit completes.
//   Undefined : overflow is tied to 0 and no sign registers are built.
// ---------------------------------------------------------------------------
module serial_borrow_subtractor #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         borrow_out,
    output logic         overflow
);

    localparam int DIGITS = N / W;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_a_sh;
    logic [N-1:0]   r_b_sh;
    logic [N-1:0]   r_res;
    logic           r_borrow;
    logic           r_borrow_out;
    logic           r_out_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [W:0]     w_sum;
    logic [W-1:0]   w_d;
    logic [N-1:0]   w_res_next;
    logic           w_accept;
    logic           w_finish;

    // Subtraction as a + ~b + ~borrow: the carry out of the digit is the
    // inverse of the borrow into the next digit.
    always_comb begin
        w_sum      = {1'b0, r_a_sh[W-1:0]} + {1'b0, ~r_b_sh[W-1:0]}
                   + {{W{1'b0}}, ~r_borrow};
        w_d        = w_sum[W-1:0];
        // New digit enters at the MSB end; written as shifts so W == N works.
        w_res_next = (r_res >> W) | (N'(w_d) << (N - W));
    end

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_finish = (r_state == RUN) && (r_cnt == LAST_DIGIT);

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge value of every other register, matching the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_res        <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
            r_out_valid  <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_borrow <= borrow_in;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_borrow <= ~w_sum[W];
                    r_res    <= w_res_next;
                    r_a_sh   <= r_a_sh >> W;
                    r_b_sh   <= r_b_sh >> W;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_finish) begin
                        r_borrow_out <= ~w_sum[W];
                        r_out_valid  <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign c          = r_res;
    assign borrow_out = r_borrow_out;
    assign out_valid  = r_out_valid;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_sign_a;
    logic r_sign_b;
    logic r_overflow;

    // The final digit's MSB is the result sign bit, so overflow is known on
    // the same edge that completes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign_a <= a[N-1];
                r_sign_b <= b[N-1];
            end
            if (w_finish) begin
                r_overflow <= (r_sign_a != r_sign_b) && (w_d[W-1] != r_sign_a);
            end
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// ---------------------------------------------------------------------------
// Testbench for serial_borrow_subtractor (N=32, W=8, 4 digit cycles).
// Directed vectors with hand-computed results, backpressure hold, and
// reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_serial_borrow_subtractor;

    localparam int N      = 32;
    localparam int W      = 8;
    localparam int DIGITS = N / W;

`ifdef SERIAL_SUB_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         borrow_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        logic [N-1:0] c;
        logic         bo;
        logic         sovf;   // signed overflow when the feature is built
    } vec_t;

    serial_borrow_subtractor #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .c          (c),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        checks++;
        if (c !== '0 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: c=%h bo=%b ovf=%b, required 0/0/0", c, borrow_out, overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        vec_t vecs[7];
        logic exp_ovf;
        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        vecs[6] = '{32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0};
        for (int v = 0; v < 7; v++) begin
            exp_ovf = OVF_EN & vecs[v].sovf;
            @(negedge clk);
            a         = vecs[v].a;
            b         = vecs[v].b;
            borrow_in = vecs[v].bin;
            in_valid  = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_in_ready: got %b, required 1", v, in_ready);
            end
            @(posedge clk);
            for (int k = 0; k <= DIGITS; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    in_valid = 1'b0;
                    a        = ~a;   // ignored outside acceptance
                end
                checks++;
                if (out_valid !== (k == DIGITS)) begin
                    errors++;
                    $display("FAIL vec%0d_latency_k%0d: out_valid=%b, required %b", v, k, out_valid, (k == DIGITS));
                end
                if (k < DIGITS) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL vec%0d_busy_k%0d: in_ready=%b, required 0", v, k, in_ready);
                    end
                end
            end
            checks++;
            if (c !== vecs[v].c) begin
                errors++;
                $display("FAIL vec%0d_c: got %h, required %h", v, c, vecs[v].c);
            end
            checks++;
            if (borrow_out !== vecs[v].bo) begin
                errors++;
                $display("FAIL vec%0d_borrow_out: got %b, required %b", v, borrow_out, vecs[v].bo);
            end
            checks++;
            if (overflow !== exp_ovf) begin
                errors++;
                $display("FAIL vec%0d_overflow: got %b, required %b", v, overflow, exp_ovf);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_release: out_valid=%b in_ready=%b, required 0/1", v, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        // First op: 0x12345678 - 0x11111111 = 0x01234567
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (DIGITS) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_valid: out_valid=%b, required 1", out_valid);
        end
        // New operands offered while the result is held: 0x10 - 0x20 = 0xFFFFFFF0
        a = 32'h0000_0010; b = 32'h0000_0020; borrow_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || c !== 32'h0123_4567 ||
                borrow_out !== 1'b0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: ov=%b ir=%b c=%h bo=%b ovf=%b, required 1/0/01234567/0/0",
                         i, out_valid, in_ready, c, borrow_out, overflow);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: in_ready=%b, required 0", in_ready);
        end
        repeat (DIGITS) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || c !== 32'hFFFF_FFF0 || borrow_out !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_result: ov=%b c=%h bo=%b ovf=%b, required 1/fffffff0/1/0",
                     out_valid, c, borrow_out, overflow);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        a = 32'h5555_5555; b = 32'h1111_1111; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);     // first RUN cycle
        in_valid = 1'b0;
        @(negedge clk);     // second RUN cycle
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== '0 ||
            borrow_out !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ir=%b ov=%b c=%h bo=%b ovf=%b, required 1/0/0/0/0",
                     in_ready, out_valid, c, borrow_out, overflow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DIGITS + 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_no_pulse_%0d: out_valid=%b in_ready=%b, required 0/1", i, out_valid, in_ready);
            end
        end
        a = 32'd10; b = 32'd4; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (DIGITS) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || c !== 32'd6 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_result: ov=%b c=%h bo=%b ovf=%b, required 1/00000006/0/0",
                     out_valid, c, borrow_out, overflow);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
